// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and request/acknowledge instruction-fetch
// sequencer for the monocycle core.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word-aligned)
//   TIMEOUT   max FETCH cycles without fetchAck before a fetch error (1..255)
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   nextPc        next address from the branch/next mux, consumed in EXEC
//   stall         holds the current instruction in EXEC
//   fetchAck      memory acknowledge, only honoured while fetchReq=1
//   fetchInstr    instruction word, valid with fetchAck
//   fetchReq      fetch request (state == FETCH)
//   fetchAddr     fetch address, always equal to pc
//   pc, pcPlus4   current PC and pc + 4 (wraps modulo 2^32)
//   instr         latched instruction
//   instrValid    instr is executable this cycle (state == EXEC)
//   retired       retired-instruction counter (wraps)
//   misaligned    sticky: a target with nextPc[1:0] != 0 was rejected
//   fetchErr      sticky: fetch timed out

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd32,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nextPc,
    input  logic        stall,
    input  logic        fetchAck,
    input  logic [31:0] fetchInstr,
    output logic        fetchReq,
    output logic [31:0] fetchAddr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] retired,
    output logic        misaligned,
    output logic        fetchErr
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    // waitCnt holds the number of completed ack-less FETCH cycles, so the
    // TIMEOUT-th ack-less cycle is the one that sees TIMEOUT-1.
    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        misaligned_q, misaligned_d;
    logic        fetch_err_q, fetch_err_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        retired_d    = retired_q;
        wait_cnt_d   = wait_cnt_q;
        misaligned_d = misaligned_q;
        fetch_err_d  = fetch_err_q;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = 8'd0;
                state_d    = StFetch;
            end
            StFetch: begin
                // Ack wins over the timeout in the same cycle.
                if (fetchAck) begin
                    instr_d = fetchInstr;
                    state_d = StExec;
                end else if (wait_cnt_q == LastWait) begin
                    fetch_err_d = 1'b1;
                    state_d     = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StExec: begin
                if (!stall) begin
                    if (nextPc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = StHalt;
                    end else begin
                        pc_d       = nextPc;
                        retired_d  = retired_q + 32'd1;
                        wait_cnt_d = 8'd0;
                        state_d    = StFetch;
                    end
                end
            end
            StHalt: begin
                // Terminal: everything frozen until reset.
            end
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            retired_q    <= 32'd0;
            wait_cnt_q   <= 8'd0;
            misaligned_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            wait_cnt_q   <= wait_cnt_d;
            misaligned_q <= misaligned_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign fetchReq   = (state_q == StFetch);
    assign instrValid = (state_q == StExec);
    assign pc         = pc_q;
    assign fetchAddr  = pc_q;
    assign pcPlus4    = pc_q + 32'd4;
    assign instr      = instr_q;
    assign retired    = retired_q;
    assign misaligned = misaligned_q;
    assign fetchErr   = fetch_err_q;

endmodule
